// File: rtl/lift_pkg.sv
// Shared types, constants and the SCAN look-ahead helper for the lift car scheduler.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    localparam logic UP       = 1'b1;
    localparam logic DOWN     = 1'b0;
    localparam int   FLOOR_W  = 2;
    localparam int   N_FLOORS = 4;

    // True when some pending call lies strictly beyond cur_floor in the given direction.
    function automatic logic has_call_ahead(
        input logic [N_FLOORS-1:0] pending,
        input logic [FLOOR_W-1:0]  cur_floor,
        input logic                dir
    );
        logic ahead;
        ahead = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (dir == UP) && (i > int'(cur_floor)))
                ahead = 1'b1;
            if (pending[i] && (dir == DOWN) && (i < int'(cur_floor)))
                ahead = 1'b1;
        end
        return ahead;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter with a zero flag; shared between travel and door timing.
module lift_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // A load always wins over a decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lift_scheduler.sv
// SCAN request scheduler and motion sequencer for the 4-floor lift car.
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS      = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                dir,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                served,
    output logic [FLOOR_W-1:0]  served_floor
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t               state;
    logic [FLOOR_W-1:0]   next_floor;
    logic [N_FLOORS-1:0]  clear_mask;
    logic                 arrive;
    logic                 arrive_hit;
    logic                 idle_hit;
    logic                 idle_go;
    logic                 timer_load;
    logic                 timer_dec;
    logic                 timer_zero;
    logic [TW-1:0]        timer_val;

    // Saturating step so the car can never wrap past the end floors.
    always_comb begin
        next_floor = cur_floor;
        if ((dir == UP) && (cur_floor != FLOOR_W'(N_FLOORS - 1)))
            next_floor = cur_floor + 1'b1;
        else if ((dir == DOWN) && (cur_floor != '0))
            next_floor = cur_floor - 1'b1;
    end

    assign arrive     = (state == MOVE) && timer_zero;
    assign arrive_hit = arrive && pending[next_floor];
    assign idle_hit   = (state == IDLE) && pending[cur_floor];
    assign idle_go    = (state == IDLE) && (pending != '0) && !pending[cur_floor];

    always_comb begin
        clear_mask = '0;
        if ((state == DOOR) || idle_hit)
            clear_mask[cur_floor] = 1'b1;
        if (arrive_hit)
            clear_mask[next_floor] = 1'b1;
    end

    always_comb begin
        timer_load = 1'b0;
        timer_val  = TW'(TRAVEL_CYCLES - 1);
        if (idle_hit || arrive_hit) begin
            timer_load = 1'b1;
            timer_val  = TW'(DOOR_CYCLES - 1);
        end else if (idle_go || arrive) begin
            timer_load = 1'b1;
        end
    end

    assign timer_dec = (state != IDLE);

    lift_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Decisions look only at registered pending, so new calls act one edge after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_floor    <= '0;
            dir          <= UP;
            pending      <= '0;
            served       <= 1'b0;
            served_floor <= '0;
        end else begin
            pending <= (pending | req) & ~clear_mask;
            served  <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_hit) begin
                        state        <= DOOR;
                        served       <= 1'b1;
                        served_floor <= cur_floor;
                    end else if (idle_go) begin
                        state <= MOVE;
                        if (!has_call_ahead(pending, cur_floor, dir))
                            dir <= ~dir;
                    end
                end
                MOVE: begin
                    if (arrive) begin
                        cur_floor <= next_floor;
                        if (arrive_hit) begin
                            state        <= DOOR;
                            served       <= 1'b1;
                            served_floor <= next_floor;
                        end
                    end
                end
                DOOR: begin
                    if (timer_zero)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

endmodule
